prog_pla: RTL and testbench

- Parametrised, run-time programmable PLA: N_IN inputs, N_TERM product terms, N_OUT outputs.
- AND-plane and OR-plane are held in registers and loaded through a valid/ready configuration port.
- Input vectors are evaluated through a 2-stage pipeline: product-term register, then output register.
- Successor to the fixed 4-in/4-out PLA; used wherever a small reconfigurable logic function sits between control blocks.

---
 rtl/prog_pla_if.sv | 32 +++
 rtl/prog_pla.sv | 103 ++++++++++
 tb/tb_prog_pla.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_pla_if.sv
// rtl/prog_pla_if.sv - config, input and output bundle of the programmable PLA
interface prog_pla_if #(
    parameter int N_IN   = 4,
    parameter int N_TERM = 8,
    parameter int N_OUT  = 4
);
    localparam int CFG_W   = (2 * N_IN > N_TERM + 1) ? 2 * N_IN : N_TERM + 1;
    localparam int MAX_IDX = (N_TERM > N_OUT) ? N_TERM : N_OUT;
    localparam int AW      = (MAX_IDX > 1) ? $clog2(MAX_IDX) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_plane;
    logic [AW-1:0]    cfg_addr;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_err;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_data;
    logic             out_valid;
    logic [N_OUT-1:0] out_data;

    modport master (
        output cfg_valid, cfg_plane, cfg_addr, cfg_data, in_valid, in_data,
        input  cfg_ready, cfg_err, in_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_valid, cfg_plane, cfg_addr, cfg_data, in_valid, in_data,
        output cfg_ready, cfg_err, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/prog_pla.sv
// rtl/prog_pla.sv - run-time programmable PLA with registered AND/OR planes and 2-stage pipeline
module prog_pla #(
    parameter int N_IN   = 4,
    parameter int N_TERM = 8,
    parameter int N_OUT  = 4
) (
    input logic       clk,
    input logic       rst_n,
    prog_pla_if.slave bus
);
    localparam int MAX_IDX = (N_TERM > N_OUT) ? N_TERM : N_OUT;
    localparam int AW      = (MAX_IDX > 1) ? $clog2(MAX_IDX) : 1;

    logic [N_IN-1:0]   and_t  [N_TERM];
    logic [N_IN-1:0]   and_c  [N_TERM];
    logic [N_TERM-1:0] or_sel [N_OUT];
    logic [N_OUT-1:0]  or_inv;

    logic [N_TERM-1:0] term_d;
    logic [N_TERM-1:0] term_q;
    logic              v1;
    logic [N_OUT-1:0]  out_d;
    logic [N_OUT-1:0]  out_q;
    logic              out_v;
    logic              err_q;

    logic in_fire;
    logic cfg_fire;
    logic addr_ok;

    // Config waits for an empty pipeline so in-flight vectors never see a half-updated plane.
    assign bus.in_ready  = ~bus.cfg_valid;
    assign bus.cfg_ready = ~v1 & ~out_v;
    assign in_fire       = bus.in_valid & ~bus.cfg_valid;
    assign cfg_fire      = bus.cfg_valid & ~v1 & ~out_v;
    assign addr_ok       = bus.cfg_plane ? (32'(bus.cfg_addr) < N_OUT)
                                         : (32'(bus.cfg_addr) < N_TERM);

    assign bus.out_valid = out_v;
    assign bus.out_data  = out_q;
    assign bus.cfg_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < N_TERM; t++) begin
                and_t[t] <= '0;
                and_c[t] <= '0;
            end
            for (int o = 0; o < N_OUT; o++) begin
                or_sel[o] <= '0;
            end
            or_inv <= '0;
        end else if (cfg_fire && addr_ok) begin
            for (int t = 0; t < N_TERM; t++) begin
                if (!bus.cfg_plane && bus.cfg_addr == AW'(t)) begin
                    and_t[t] <= bus.cfg_data[N_IN-1:0];
                    and_c[t] <= bus.cfg_data[2*N_IN-1:N_IN];
                end
            end
            for (int o = 0; o < N_OUT; o++) begin
                if (bus.cfg_plane && bus.cfg_addr == AW'(o)) begin
                    or_sel[o] <= bus.cfg_data[N_TERM-1:0];
                    or_inv[o] <= bus.cfg_data[N_TERM];
                end
            end
        end
    end

    // A set true-mask bit demands x[i]=1, a set complement-mask bit demands x[i]=0.
    always_comb begin
        term_d = '0;
        for (int t = 0; t < N_TERM; t++) begin
            term_d[t] = &((~and_t[t] | bus.in_data) & (~and_c[t] | ~bus.in_data));
        end
    end

    always_comb begin
        out_d = '0;
        for (int o = 0; o < N_OUT; o++) begin
            out_d[o] = (|(term_q & or_sel[o])) ^ or_inv[o];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_q <= '0;
            v1     <= 1'b0;
            out_q  <= '0;
            out_v  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            v1 <= in_fire;
            if (in_fire) begin
                term_q <= term_d;
            end
            out_v <= v1;
            if (v1) begin
                out_q <= out_d;
            end
            err_q <= cfg_fire & ~addr_ok;
        end
    end
endmodule

// File: tb/tb_prog_pla.sv
// tb/tb_prog_pla.sv - randomized and directed checks of prog_pla against a truth-rule model
module tb_prog_pla;
    localparam int N_IN   = 4;
    localparam int N_TERM = 8;
    localparam int N_OUT  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prog_pla_if #(.N_IN(N_IN), .N_TERM(N_TERM), .N_OUT(N_OUT)) bus ();
    prog_pla #(.N_IN(N_IN), .N_TERM(N_TERM), .N_OUT(N_OUT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int         due;
        logic [3:0] val;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_and [8];
    logic [8:0] m_or  [4];
    int         cyc;
    int         last_acc;
    int         errors;
    int         checks;
    int         n_out;
    logic [3:0] last_out;
    bit         const_chk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] model(input logic [3:0] x);
        logic [7:0] terms;
        logic [3:0] r;
        for (int t = 0; t < 8; t++) begin
            terms[t] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (m_and[t][i] && !x[i]) terms[t] = 1'b0;
                if (m_and[t][4+i] && x[i]) terms[t] = 1'b0;
            end
        end
        for (int o = 0; o < 4; o++) begin
            r[o] = ((terms & m_or[o][7:0]) != 8'd0) ^ m_or[o][8];
        end
        return r;
    endfunction

    // One clock: check ready signals, predict accepts, then check outputs just after the edge.
    task automatic tick(output bit acc_in, output bit acc_cfg);
        bit         ok;
        bit         plane;
        logic [2:0] addr;
        logic [8:0] data;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!bus.cfg_valid));
        chk("cfg_ready", 32'(bus.cfg_ready), 32'(cyc >= last_acc + 3));
        acc_in  = bus.in_valid && !bus.cfg_valid;
        acc_cfg = bus.cfg_valid && (cyc >= last_acc + 3);
        plane   = bus.cfg_plane;
        addr    = bus.cfg_addr;
        data    = bus.cfg_data;
        ok      = plane ? (addr < 3'd4) : 1'b1;
        if (acc_in) begin
            exp_q.push_back('{due: cyc + 2, val: model(bus.in_data)});
            last_acc = cyc;
        end
        @(posedge clk);
        cyc++;
        if (acc_cfg && ok) begin
            if (plane) m_or[addr[1:0]] = data;
            else       m_and[addr] = data[7:0];
        end
        #1;
        chk("cfg_err", 32'(bus.cfg_err), 32'(acc_cfg && !ok));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("out_valid", 32'(bus.out_valid), 32'd1);
            chk("out_data", 32'(bus.out_data), 32'(exp_q[0].val));
            if (const_chk) begin
                chk("out1_inv_empty", 32'(bus.out_data[1]), 32'd1);
                chk("out2_conflict", 32'(bus.out_data[2]), 32'd0);
            end
            last_out = exp_q[0].val;
            void'(exp_q.pop_front());
            n_out++;
        end else begin
            chk("out_idle", 32'(bus.out_valid), 32'd0);
            chk("out_hold", 32'(bus.out_data), 32'(last_out));
        end
        @(negedge clk);
    endtask

    task automatic cfg_write(input bit plane, input logic [2:0] addr, input logic [8:0] data,
                             output int waits);
        bit ai, ac;
        ac = 1'b0;
        waits = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_plane = plane;
        bus.cfg_addr  = addr;
        bus.cfg_data  = data;
        while (!ac && waits < 6) begin
            tick(ai, ac);
            waits++;
        end
        if (!ac) chk("cfg_accept_timeout", 32'd0, 32'd1);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic send_one(input logic [3:0] x, input logic [3:0] expv, input string tag);
        bit ai, ac;
        bus.in_data  = x;
        bus.in_valid = 1'b1;
        tick(ai, ac);
        bus.in_valid = 1'b0;
        tick(ai, ac);
        tick(ai, ac);
        chk(tag, 32'(bus.out_data), 32'(expv));
    endtask

    task automatic stream_all(input bit rnd);
        bit ai, ac;
        n_out = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_data = rnd ? 4'($urandom) : 4'(i);
            tick(ai, ac);
        end
        bus.in_valid = 1'b0;
        repeat (3) tick(ai, ac);
        chk("stream_count", 32'(n_out), 32'd16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ai, ac, arb_done;
        int waits;
        errors = 0; checks = 0; cyc = 0; last_acc = -10; n_out = 0;
        last_out = 4'd0; const_chk = 1'b0;
        for (int t = 0; t < 8; t++) m_and[t] = '0;
        for (int o = 0; o < 4; o++) m_or[o] = '0;
        bus.cfg_valid = 1'b0; bus.cfg_plane = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        rst_n = 1'b1;
        tick(ai, ac);

        // Reset in the middle of a stream: the in-flight vectors must vanish.
        bus.in_valid = 1'b1;
        repeat (3) begin
            bus.in_data = 4'($urandom);
            tick(ai, ac);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_out_data", 32'(bus.out_data), 32'd0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        last_out = 4'd0;
        last_acc = cyc - 10;
        rst_n = 1'b1;
        repeat (3) tick(ai, ac);
        send_one(4'b1011, 4'b0000, "reset_default_eval");

        // Directed program: out0 = A&B | ~C&D, out1 = empty inverted, out2 = contradictory term.
        cfg_write(1'b0, 3'd0, 9'b0_0000_0011, waits);
        cfg_write(1'b0, 3'd1, 9'b0_0100_1000, waits);
        cfg_write(1'b0, 3'd2, 9'b0_0001_0001, waits);
        cfg_write(1'b1, 3'd0, 9'b0_0000_0011, waits);
        cfg_write(1'b1, 3'd1, 9'b1_0000_0000, waits);
        cfg_write(1'b1, 3'd2, 9'b0_0000_0100, waits);
        send_one(4'b0011, 4'b0011, "abcd_1100");
        send_one(4'b1000, 4'b0011, "abcd_0001");
        send_one(4'b1100, 4'b0010, "abcd_0011");
        const_chk = 1'b1;
        stream_all(1'b0);
        const_chk = 1'b0;

        // Out-of-range OR address: accepted, flagged, no plane change.
        cfg_write(1'b1, 3'd5, 9'($urandom), waits);
        chk("err_write_wait", 32'(waits), 32'd1);
        stream_all(1'b0);

        // Random reprogramming followed by random vectors.
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(1, 0) == 1) cfg_write(1'b1, 3'($urandom_range(3, 0)), 9'($urandom), waits);
            else                           cfg_write(1'b0, 3'($urandom_range(7, 0)), 9'($urandom), waits);
        end
        stream_all(1'b1);

        // Config request while streaming: inputs stall, write waits for the pipeline to drain.
        arb_done = 1'b0;
        waits = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.in_data = 4'($urandom);
            if (i == 5) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_plane = 1'b1;
                bus.cfg_addr  = 3'd3;
                bus.cfg_data  = 9'h0FF ^ m_or[3];
            end
            if (bus.cfg_valid) waits++;
            tick(ai, ac);
            if (ac) begin
                bus.cfg_valid = 1'b0;
                arb_done = 1'b1;
                chk("arb_wait", 32'(waits), 32'd3);
            end
        end
        bus.in_valid = 1'b0;
        bus.cfg_valid = 1'b0;
        repeat (3) tick(ai, ac);
        chk("arb_accepted", 32'(arb_done), 32'd1);

        // Back-to-back writes to the same AND entry: one per cycle, last one wins.
        bus.cfg_valid = 1'b1;
        bus.cfg_plane = 1'b0;
        bus.cfg_addr  = 3'd3;
        bus.cfg_data  = 9'($urandom);
        tick(ai, ac);
        chk("b2b_first", 32'(ac), 32'd1);
        bus.cfg_data  = 9'($urandom);
        tick(ai, ac);
        chk("b2b_second", 32'(ac), 32'd1);
        bus.cfg_valid = 1'b0;
        cfg_write(1'b1, 3'd0, 9'h008, waits);
        stream_all(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
